// File: rtl/elevador_pkg.sv
// Shared types and constants for the elevator call-panel front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elevador_pkg;

    // Number of floors served; width of every call vector.
    localparam int N_ANDARES = 5;

    // Floor index as reported by the movement controller.
    typedef logic [2:0] andar_t;

    // 20 ms of stability at 50 MHz before a button level is believed.
    localparam int DEBOUNCE_CICLOS_PADRAO = 1_000_000;

    // Conditioned inputs: floor calls occupy [N_ANDARES-1:0], then the car buttons.
    localparam int IDX_ENTRA      = N_ANDARES;
    localparam int IDX_SAI        = N_ANDARES + 1;
    localparam int IDX_EMERGENCIA = N_ANDARES + 2;
    localparam int N_BOTOES       = N_ANDARES + 3;

endpackage

// File: rtl/painel_chamadas_if.sv
// Bundle between board pins / elevator controller and the call panel.
// Latency: n/a (wiring only).
// Backpressure: none; raw levels in, registered levels and pulses out.
interface painel_chamadas_if;

    logic [elevador_pkg::N_ANDARES-1:0] botoes_chamar;
    logic                               botao_pessoa_entra;
    logic                               botao_pessoa_sai;
    logic                               botao_emergencia;
    logic                               lotado;
    logic                               atendido_valid;
    elevador_pkg::andar_t               atendido_andar;
    logic [elevador_pkg::N_ANDARES-1:0] chamadas_pendentes;
    logic                               pulso_entra;
    logic                               pulso_sai;
    logic                               pulso_emergencia;

    // Board + controller side: drives buttons and service reports.
    modport master (
        output botoes_chamar, botao_pessoa_entra, botao_pessoa_sai, botao_emergencia,
        output lotado, atendido_valid, atendido_andar,
        input  chamadas_pendentes, pulso_entra, pulso_sai, pulso_emergencia
    );

    // Call panel side.
    modport slave (
        input  botoes_chamar, botao_pessoa_entra, botao_pessoa_sai, botao_emergencia,
        input  lotado, atendido_valid, atendido_andar,
        output chamadas_pendentes, pulso_entra, pulso_sai, pulso_emergencia
    );

endinterface

// File: rtl/condicionador_botao.sv
// One raw button: 2-FF synchroniser, debounce (only with PAINEL_DEBOUNCE_EN defined), rising-edge pulse.
// Latency: press first sampled at edge k -> pulse after edge k+2+DEBOUNCE_CICLOS (k+3 without debounce), 1 cycle.
// Backpressure: none; free-running, exactly one pulse per debounced press, none on release.
module condicionador_botao
    import elevador_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic clock_50MHz,
    input  logic reset_geral,
    input  logic botao_bruto,
    output logic pulso
);

    if (DEBOUNCE_CICLOS < 1) begin : g_parametro_invalido
        $error("DEBOUNCE_CICLOS must be at least 1");
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic estavel_q, estavel_d;
    logic estavel_ant_q, estavel_ant_d;
    logic pulso_q, pulso_d;

`ifdef PAINEL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    // The transfer happens on the edge where the count would reach
    // DEBOUNCE_CICLOS, so the stored value never exceeds DEBOUNCE_CICLOS-1
    // and the counter can neither wrap nor overflow.
    localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CICLOS - 1);

    logic [CW-1:0] contador_q, contador_d;

    // Debounce: count consecutive samples that disagree with the stable level.
    always_comb begin
        estavel_d  = estavel_q;
        contador_d = contador_q;
        if (sync2_q == estavel_q) begin
            contador_d = '0;
        end else if (contador_q >= ULTIMO) begin
            estavel_d  = sync2_q;
            contador_d = '0;
        end else begin
            contador_d = contador_q + CW'(1);
        end
    end

    // Debounce counter register; a reset discards any partial count.
    always_ff @(posedge clock_50MHz) begin
        if (reset_geral) begin
            contador_q <= '0;
        end else begin
            contador_q <= contador_d;
        end
    end
`else
    // Without debounce the stable level is just the synchronised sample.
    always_comb begin
        estavel_d = sync2_q;
    end
`endif

    // Synchroniser shift and registered rising-edge detect.
    always_comb begin
        sync1_d       = botao_bruto;
        sync2_d       = sync1_q;
        estavel_ant_d = estavel_q;
        pulso_d       = estavel_q & ~estavel_ant_q;
    end

    // Pipeline registers, all cleared by the synchronous reset.
    always_ff @(posedge clock_50MHz) begin
        if (reset_geral) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            estavel_q     <= 1'b0;
            estavel_ant_q <= 1'b0;
            pulso_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            estavel_q     <= estavel_d;
            estavel_ant_q <= estavel_ant_d;
            pulso_q       <= pulso_d;
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/painel_chamadas.sv
// Call panel: conditions 8 raw buttons into pulses and keeps the pending floor-call register.
// Latency: pulse as in condicionador_botao; pending set one edge after the call pulse, cleared at the edge atendido_valid is sampled.
// Backpressure: none; calls arriving while lotado=1 are dropped, not deferred.
module painel_chamadas
    import elevador_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic               clock_50MHz,
    input  logic               reset_geral,
    painel_chamadas_if.slave   bus
);

    logic [N_BOTOES-1:0]  botoes_brutos;
    logic [N_BOTOES-1:0]  pulsos;
    logic [N_ANDARES-1:0] pendentes_q, pendentes_d;

    // Gather every raw button into one vector laid out by the package indices.
    always_comb begin
        botoes_brutos                 = '0;
        botoes_brutos[N_ANDARES-1:0]  = bus.botoes_chamar;
        botoes_brutos[IDX_ENTRA]      = bus.botao_pessoa_entra;
        botoes_brutos[IDX_SAI]        = bus.botao_pessoa_sai;
        botoes_brutos[IDX_EMERGENCIA] = bus.botao_emergencia;
    end

    for (genvar g = 0; g < N_BOTOES; g++) begin : g_cond
        condicionador_botao #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
        ) u_cond (
            .clock_50MHz(clock_50MHz),
            .reset_geral(reset_geral),
            .botao_bruto(botoes_brutos[g]),
            .pulso      (pulsos[g])
        );
    end

    // Pending calls: set, then served-floor clear, then emergency wipe (later wins).
    always_comb begin
        pendentes_d = pendentes_q;
        if (!bus.lotado) begin
            pendentes_d = pendentes_d | pulsos[N_ANDARES-1:0];
        end
        if (bus.atendido_valid) begin
            for (int i = 0; i < N_ANDARES; i++) begin
                if (bus.atendido_andar == andar_t'(i)) begin
                    pendentes_d[i] = 1'b0;
                end
            end
        end
        if (pulsos[IDX_EMERGENCIA]) begin
            pendentes_d = '0;
        end
    end

    // Pending-call register.
    always_ff @(posedge clock_50MHz) begin
        if (reset_geral) begin
            pendentes_q <= '0;
        end else begin
            pendentes_q <= pendentes_d;
        end
    end

    assign bus.chamadas_pendentes = pendentes_q;
    assign bus.pulso_entra        = pulsos[IDX_ENTRA];
    assign bus.pulso_sai          = pulsos[IDX_SAI];
    assign bus.pulso_emergencia   = pulsos[IDX_EMERGENCIA];

endmodule

// File: tb/tb_painel_chamadas.sv
// Self-checking bench for painel_chamadas with a sample-history reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_painel_chamadas;
    import elevador_pkg::*;

    localparam int D_TB = 4;
`ifdef PAINEL_DEBOUNCE_EN
    localparam int D_EFF = D_TB;
`else
    localparam int D_EFF = 1;   // no debounce: level follows each sample
`endif
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic rst;
    painel_chamadas_if bus();

    painel_chamadas #(.DEBOUNCE_CICLOS(D_TB)) dut (
        .clock_50MHz(clk),
        .reset_geral(rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2:0] pobs;
    assign pobs = {bus.pulso_emergencia, bus.pulso_sai, bus.pulso_entra};

    // Reference model: raw samples per edge, debounced level per edge.
    logic [7:0] raw_h [MAXE];
    logic [7:0] lvl_h [MAXE];
    int         run_c [8];
    int         e      = 1;
    int         r_edge = 0;
    logic [7:0] m_pulse = '0;
    logic [4:0] m_pend  = '0;

    task automatic model_step();
        logic [7:0] raw8;
        logic [7:0] lvl;
        logic       s;
        e++;
        if (e >= MAXE) begin
            $display("FAIL model_capacity edge=%0d limit=%0d", e, MAXE);
            $fatal(1);
        end
        raw8     = {bus.botao_emergencia, bus.botao_pessoa_sai, bus.botao_pessoa_entra, bus.botoes_chamar};
        raw_h[e] = raw8;
        if (rst) begin
            r_edge   = e;
            lvl_h[e] = '0;
            for (int i = 0; i < 8; i++) run_c[i] = 0;
            m_pulse  = '0;
            m_pend   = '0;
        end else begin
            // Calls pulsing in the cycle just ended, unless the car is full.
            if (!bus.lotado) m_pend = m_pend | m_pulse[4:0];
            if (bus.atendido_valid && bus.atendido_andar < 5) m_pend[bus.atendido_andar] = 1'b0;
            if (m_pulse[7]) m_pend = '0;
            // Level flips after D_EFF consecutive samples of the other value;
            // a sample reaches the debouncer two edges after being taken.
            for (int i = 0; i < 8; i++) begin
                s      = (e - 2 > r_edge) ? raw_h[e-2][i] : 1'b0;
                lvl[i] = lvl_h[e-1][i];
                if (s != lvl[i]) begin
                    run_c[i]++;
                    if (run_c[i] >= D_EFF) begin
                        lvl[i]   = s;
                        run_c[i] = 0;
                    end
                end else begin
                    run_c[i] = 0;
                end
            end
            lvl_h[e] = lvl;
            m_pulse  = lvl_h[e-1] & ~lvl_h[e-2];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            checks++;
            if (bus.chamadas_pendentes !== 5'b00000 || pobs !== 3'b000) begin
                failures++;
                $display("FAIL reset pend=%b pulses=%b want pend=00000 pulses=000", bus.chamadas_pendentes, pobs);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        int first = 0;
        bus.botoes_chamar = 5'b10000;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (first == 0 && bus.chamadas_pendentes[4] === 1'b1) first = t;
            checks++;
            if (bus.chamadas_pendentes !== m_pend || pobs !== m_pulse[7:5]) begin
                failures++;
                $display("FAIL clean_press t=%0d pend=%b want %b pulses=%b want %b", t, bus.chamadas_pendentes, m_pend, pobs, m_pulse[7:5]);
            end
        end
        checks++;
        if (first != D_EFF + 4 || bus.chamadas_pendentes !== 5'b10000) begin
            failures++;
            $display("FAIL clean_press_latency cycles=%0d want %0d pend=%b want 10000", first, D_EFF + 4, bus.chamadas_pendentes);
        end
        bus.botoes_chamar = '0;
        for (int t = 0; t < D_EFF + 4; t++) tick();
    endtask

    task automatic test_bounce();
        int n = 0;
        logic [3:0] seq = 4'b0101;   // applied LSB first: 1,0,1,0
        for (int t = 0; t < 4 + 10 + D_EFF + 4; t++) begin
            if (t < 4) bus.botao_pessoa_entra = seq[t];
            else if (t < 14) bus.botao_pessoa_entra = 1'b1;
            else bus.botao_pessoa_entra = 1'b0;
            tick();
            if (bus.pulso_entra === 1'b1) n++;
            checks++;
            if (bus.chamadas_pendentes !== m_pend || pobs !== m_pulse[7:5]) begin
                failures++;
                $display("FAIL bounce t=%0d pend=%b want %b pulses=%b want %b", t, bus.chamadas_pendentes, m_pend, pobs, m_pulse[7:5]);
            end
        end
        checks++;
        if (n != ((D_EFF > 1) ? 1 : 3)) begin
            failures++;
            $display("FAIL bounce_count pulses=%0d want %0d", n, (D_EFF > 1) ? 1 : 3);
        end
    endtask

    task automatic test_served_clear();
        bus.atendido_valid = 1'b1;
        bus.atendido_andar = 3'd4;
        tick();
        bus.atendido_valid = 1'b0;
        bus.botoes_chamar  = 5'b01010;
        for (int t = 0; t < D_EFF + 6; t++) tick();
        bus.botoes_chamar = '0;
        for (int t = 0; t < D_EFF + 4; t++) tick();
        checks++;
        if (bus.chamadas_pendentes !== 5'b01010) begin
            failures++;
            $display("FAIL served_setup pend=%b want 01010", bus.chamadas_pendentes);
        end
        bus.atendido_valid = 1'b1;
        bus.atendido_andar = 3'd3;
        tick();
        checks++;
        if (bus.chamadas_pendentes !== 5'b00010) begin
            failures++;
            $display("FAIL served_clear pend=%b want 00010", bus.chamadas_pendentes);
        end
        bus.atendido_andar = 3'd7;
        tick();
        checks++;
        if (bus.chamadas_pendentes !== 5'b00010) begin
            failures++;
            $display("FAIL served_out_of_range pend=%b want 00010", bus.chamadas_pendentes);
        end
        bus.atendido_andar = 3'd1;
        tick();
        bus.atendido_valid = 1'b0;
        checks++;
        if (bus.chamadas_pendentes !== 5'b00000 || m_pend !== 5'b00000) begin
            failures++;
            $display("FAIL served_clear_last pend=%b model=%b want 00000", bus.chamadas_pendentes, m_pend);
        end
    endtask

    task automatic test_lotado();
        bus.lotado        = 1'b1;
        bus.botoes_chamar = 5'b00010;
        for (int t = 0; t < D_EFF + 8; t++) tick();
        checks++;
        if (bus.chamadas_pendentes !== 5'b00000) begin
            failures++;
            $display("FAIL lotado_full pend=%b want 00000", bus.chamadas_pendentes);
        end
        bus.lotado = 1'b0;
        for (int t = 0; t < 10; t++) tick();
        checks++;
        if (bus.chamadas_pendentes !== 5'b00000) begin
            failures++;
            $display("FAIL lotado_no_new_edge pend=%b want 00000", bus.chamadas_pendentes);
        end
        bus.botoes_chamar = '0;
        for (int t = 0; t < D_EFF + 4; t++) tick();
    endtask

    task automatic test_emergency();
        bus.botoes_chamar = 5'b11111;
        for (int t = 0; t < D_EFF + 6; t++) tick();
        bus.botoes_chamar = '0;
        for (int t = 0; t < D_EFF + 4; t++) tick();
        checks++;
        if (bus.chamadas_pendentes !== 5'b11111) begin
            failures++;
            $display("FAIL emergency_setup pend=%b want 11111", bus.chamadas_pendentes);
        end
        bus.botoes_chamar    = 5'b00100;
        bus.botao_emergencia = 1'b1;
        for (int t = 1; t <= D_EFF + 6; t++) begin
            tick();
            checks++;
            if (bus.chamadas_pendentes !== m_pend || pobs !== m_pulse[7:5]) begin
                failures++;
                $display("FAIL emergency t=%0d pend=%b want %b pulses=%b want %b", t, bus.chamadas_pendentes, m_pend, pobs, m_pulse[7:5]);
            end
        end
        checks++;
        if (bus.chamadas_pendentes !== 5'b00000) begin
            failures++;
            $display("FAIL emergency_wipe pend=%b want 00000", bus.chamadas_pendentes);
        end
        bus.botoes_chamar    = '0;
        bus.botao_emergencia = 1'b0;
        for (int t = 0; t < D_EFF + 4; t++) tick();
        // Floor-4 call pulse coincides with the controller serving floor 4.
        bus.botoes_chamar = 5'b10000;
        for (int t = 1; t <= D_EFF + 3; t++) tick();
        bus.atendido_valid = 1'b1;
        bus.atendido_andar = 3'd4;
        tick();
        checks++;
        if (bus.chamadas_pendentes[4] !== 1'b0) begin
            failures++;
            $display("FAIL clear_priority pend=%b want bit4=0", bus.chamadas_pendentes);
        end
        bus.atendido_valid = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        checks++;
        if (bus.chamadas_pendentes !== 5'b00000) begin
            failures++;
            $display("FAIL clear_priority_hold pend=%b want 00000", bus.chamadas_pendentes);
        end
        bus.botoes_chamar = '0;
        for (int t = 0; t < D_EFF + 4; t++) tick();
    endtask

    task automatic test_reset_mid_press();
        int first = 0;
        bus.botoes_chamar = 5'b00001;
        for (int t = 0; t < 4; t++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.chamadas_pendentes !== 5'b00000 || pobs !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid pend=%b pulses=%b want 00000 000", bus.chamadas_pendentes, pobs);
        end
        rst = 1'b0;
        for (int t = 1; t <= 40 && first == 0; t++) begin
            tick();
            if (bus.chamadas_pendentes[0] === 1'b1) first = t;
        end
        checks++;
        if (first != D_EFF + 4) begin
            failures++;
            $display("FAIL reset_retrigger cycles=%0d want %0d (0 = timeout)", first, D_EFF + 4);
        end
        bus.botoes_chamar  = '0;
        bus.atendido_valid = 1'b1;
        bus.atendido_andar = 3'd0;
        tick();
        bus.atendido_valid = 1'b0;
        for (int t = 0; t < D_EFF + 4; t++) tick();
    endtask

    task automatic test_random();
        int hold [8];
        logic [7:0] lv;
        for (int i = 0; i < 8; i++) hold[i] = 0;
        lv = '0;
        for (int t = 0; t < 500; t++) begin
            for (int i = 0; i < 8; i++) begin
                if (hold[i] == 0) begin
                    lv[i]   = $urandom_range(0, 1) == 1;
                    hold[i] = $urandom_range(1, 2 * D_EFF + 3);
                end
                hold[i]--;
            end
            bus.botoes_chamar      = lv[4:0];
            bus.botao_pessoa_entra = lv[5];
            bus.botao_pessoa_sai   = lv[6];
            bus.botao_emergencia   = lv[7];
            bus.lotado             = $urandom_range(0, 3) == 0;
            bus.atendido_valid     = $urandom_range(0, 2) == 0;
            bus.atendido_andar     = andar_t'($urandom_range(0, 7));
            rst                    = $urandom_range(0, 99) == 0;
            tick();
            checks++;
            if (bus.chamadas_pendentes !== m_pend || pobs !== m_pulse[7:5]) begin
                failures++;
                $display("FAIL random t=%0d pend=%b want %b pulses=%b want %b", t, bus.chamadas_pendentes, m_pend, pobs, m_pulse[7:5]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1);
    end

    initial begin
        raw_h[0] = '0; raw_h[1] = '0;
        lvl_h[0] = '0; lvl_h[1] = '0;
        for (int i = 0; i < 8; i++) run_c[i] = 0;
        rst                    = 1'b1;
        bus.botoes_chamar      = '0;
        bus.botao_pessoa_entra = 1'b0;
        bus.botao_pessoa_sai   = 1'b0;
        bus.botao_emergencia   = 1'b0;
        bus.lotado             = 1'b0;
        bus.atendido_valid     = 1'b0;
        bus.atendido_andar     = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_served_clear();
        test_lotado();
        test_emergency();
        test_reset_mid_press();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
